// File: rtl/captura_pkg.sv
// Shared definitions for the OV7670 capture path: sequencer state encoding,
// default frame geometry and small helpers.
package captura_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SYNC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;

  localparam int unsigned H_PIX_DEF   = 160;
  localparam int unsigned V_LINES_DEF = 120;
  localparam int unsigned ADDR_W_DEF  = 17;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/captura_edge_det.sv
// Registered sample of a camera timing pin with combinational rise/fall
// strobes; each edge is reported on the clock edge that registers it.
module captura_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  // One-cycle delayed copy of the pin
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= 1'b0;
    else          r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/captura_frame_control.sv
// Frame-level capture sequencer: arms on start, aligns to a VSYNC frame
// boundary, owns the frame-buffer write address, gates RAM writes and
// reports frame completion plus line/frame geometry errors.
module captura_frame_control
  import captura_pkg::*;
#(
  parameter int unsigned H_PIX   = H_PIX_DEF,
  parameter int unsigned V_LINES = V_LINES_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic              PCLK,
  input  logic              RST_N,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic              start,
  input  logic              abort,
  input  logic              cont_mode,
  input  logic              we_in,
  output logic              cap_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        line_cnt,
  output logic [7:0]        frame_cnt,
  output logic              line_err,
  output logic              frame_err,
  output logic              ovf
);

  // One extra bit so a full frame count is representable even when
  // H_PIX*V_LINES equals 2^ADDR_W.
  localparam int unsigned PIX_W = ADDR_W + 1;
  localparam logic [PIX_W-1:0] FRAME_PIX = PIX_W'(H_PIX * V_LINES);
  localparam logic [PIX_W-1:0] LINE_PIX  = PIX_W'(H_PIX);
  localparam logic [7:0]       LINE_TGT  = 8'(V_LINES);

  cap_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]  r_pix;
  logic [7:0]        r_line;
  logic [7:0]        r_frame;
  logic              r_line_err;
  logic              r_frame_err;
  logic              r_ovf;
  logic              r_frame_done;

  logic             w_vs_rise;
  logic             w_vs_fall;
  logic             w_unused_href_rise;
  logic             w_href_fall;
  logic             w_cap;
  logic             w_full;
  logic             w_we;
  logic [PIX_W-1:0] w_pix_line;
  logic [7:0]       w_line_inc;
  logic [7:0]       w_lines_at_end;

  captura_edge_det u_vs_det (
    .i_clk   (PCLK),
    .i_rst_n (RST_N),
    .i_d     (VSYNC),
    .o_rise  (w_vs_rise),
    .o_fall  (w_vs_fall)
  );

  captura_edge_det u_href_det (
    .i_clk   (PCLK),
    .i_rst_n (RST_N),
    .i_d     (HREF),
    .o_rise  (w_unused_href_rise),
    .o_fall  (w_href_fall)
  );

  assign w_cap      = (r_state == ST_CAPTURE);
  assign w_full     = ({1'b0, r_addr} == FRAME_PIX);
  assign w_we       = we_in & ~w_full & w_cap;
  // A write coinciding with HREF falling belongs to the line that is ending
  assign w_pix_line = r_pix + PIX_W'(w_we);
  assign w_line_inc = sat_inc8(r_line);
  assign w_lines_at_end = w_href_fall ? w_line_inc : r_line;

  // Sequencer, write-address counter and sticky status flags
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_pix        <= '0;
      r_line       <= '0;
      r_frame      <= '0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_ovf        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state     <= ST_ARM;
              r_line_err  <= 1'b0;
              r_frame_err <= 1'b0;
              r_ovf       <= 1'b0;
              r_frame     <= '0;
            end
          end
          ST_ARM: begin
            if (w_vs_rise) r_state <= ST_SYNC;
          end
          ST_SYNC: begin
            if (w_vs_fall) begin
              r_state <= ST_CAPTURE;
              r_addr  <= '0;
              r_line  <= '0;
              r_pix   <= '0;
            end
          end
          ST_CAPTURE: begin
            if (w_we) begin
              r_addr <= r_addr + ADDR_W'(1);
              r_pix  <= w_pix_line;
            end
            if (we_in && w_full) r_ovf <= 1'b1;
            if (w_href_fall) begin
              r_line <= w_line_inc;
              r_pix  <= '0;
              if (w_pix_line != LINE_PIX) r_line_err <= 1'b1;
            end
            if (w_vs_rise) begin
              r_state      <= ST_DONE;
              r_frame_done <= 1'b1;
              r_frame      <= r_frame + 8'd1;
              if (w_lines_at_end != LINE_TGT) r_frame_err <= 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= cont_mode ? ST_SYNC : ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cap_en     = w_cap;
  assign busy       = (r_state != ST_IDLE);
  assign ram_we     = w_we;
  assign ram_addr   = r_addr;
  assign frame_done = r_frame_done;
  assign line_cnt   = r_line;
  assign frame_cnt  = r_frame;
  assign line_err   = r_line_err;
  assign frame_err  = r_frame_err;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_captura_frame_control.sv
// Directed/randomized bench for captura_frame_control using a reduced
// frame geometry; expectations come from a transaction-level model.
module tb_captura_frame_control;

  localparam int unsigned TH   = 8;
  localparam int unsigned TV   = 5;
  localparam int unsigned TA   = 6;
  localparam int unsigned FULL = TH * TV;

  logic          PCLK;
  logic          RST_N;
  logic          VSYNC;
  logic          HREF;
  logic          start;
  logic          abort;
  logic          cont_mode;
  logic          we_in;
  logic          cap_en;
  logic [TA-1:0] ram_addr;
  logic          ram_we;
  logic          busy;
  logic          frame_done;
  logic [7:0]    line_cnt;
  logic [7:0]    frame_cnt;
  logic          line_err;
  logic          frame_err;
  logic          ovf;

  captura_frame_control #(
    .H_PIX   (TH),
    .V_LINES (TV),
    .ADDR_W  (TA)
  ) dut (
    .PCLK       (PCLK),
    .RST_N      (RST_N),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .start      (start),
    .abort      (abort),
    .cont_mode  (cont_mode),
    .we_in      (we_in),
    .cap_en     (cap_en),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .busy       (busy),
    .frame_done (frame_done),
    .line_cnt   (line_cnt),
    .frame_cnt  (frame_cnt),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .ovf        (ovf)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: writes accepted this frame, pixels in current line,
  // lines this frame, frames since start, sticky flags.
  int unsigned m_writes, m_line_pix, m_lines, m_frame_cnt;
  bit          m_line_err, m_frame_err, m_ovf;
  int unsigned g_lens[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic vs, input logic href, input logic we,
                      input logic st, input logic ab);
    @(negedge PCLK);
    VSYNC = vs; HREF = href; we_in = we; start = st; abort = ab;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cap_en"},     cap_en,     0);
    chk({tag, "_ram_addr"},   ram_addr,   0);
    chk({tag, "_ram_we"},     ram_we,     0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_line_cnt"},   line_cnt,   0);
    chk({tag, "_frame_cnt"},  frame_cnt,  0);
    chk({tag, "_line_err"},   line_err,   0);
    chk({tag, "_frame_err"},  frame_err,  0);
    chk({tag, "_ovf"},        ovf,        0);
  endtask

  task automatic model_reset();
    m_writes = 0; m_line_pix = 0; m_lines = 0; m_frame_cnt = 0;
    m_line_err = 0; m_frame_err = 0; m_ovf = 0;
  endtask

  // Pulse start from IDLE with arbitrary pin activity; flags must clear
  task automatic do_start(input logic href, input logic we);
    step(0, href, we, 1, 0);
    chk("start_busy_before", busy, 0);
    m_line_err = 0; m_frame_err = 0; m_ovf = 0; m_frame_cnt = 0;
    step(0, href, we, 0, 0);
    chk("start_busy",      busy,      1);
    chk("start_ram_we",    ram_we,    0);
    chk("start_line_err",  line_err,  0);
    chk("start_frame_err", frame_err, 0);
    chk("start_ovf",       ovf,       0);
    chk("start_frame_cnt", frame_cnt, 0);
  endtask

  // Bring the sequencer into CAPTURE at a frame boundary
  task automatic sync_in(input bit from_arm);
    if (from_arm) begin
      for (int i = 0; i < 3; i++) begin
        step(0, 1'($urandom_range(0, 1)), 1, 0, 0);
        chk("arm_ram_we", ram_we, 0);
        chk("arm_cap_en", cap_en, 0);
        chk("arm_busy",   busy,   1);
      end
      for (int i = 0; i < 2; i++) begin
        step(1, 0, 1, 0, 0);
        chk("vsync_hi_ram_we", ram_we, 0);
        chk("vsync_hi_cap_en", cap_en, 0);
      end
    end
    step(1, 0, 1, 0, 0);
    chk("sync_ram_we", ram_we, 0);
    step(0, 0, 0, 0, 0);
    chk("sync_cap_en_pre", cap_en, 0);
    m_writes = 0; m_lines = 0; m_line_pix = 0;
    step(0, 0, 0, 0, 0);
    chk("cap_start_cap_en",   cap_en,   1);
    chk("cap_start_ram_addr", ram_addr, 0);
    chk("cap_start_line_cnt", line_cnt, 0);
  endtask

  task automatic cap_cycle(input logic href, input logic we);
    step(0, href, we, 0, 0);
    chk("cap_cap_en",   cap_en,   1);
    chk("cap_ram_we",   ram_we,   32'(we && (m_writes < FULL)));
    chk("cap_ram_addr", ram_addr, m_writes);
    if (we) begin
      if (m_writes < FULL) begin
        m_writes++;
        m_line_pix++;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic drive_line(input int unsigned len);
    bit on_fall;
    int unsigned pre;
    on_fall = (len > 0) && ($urandom_range(0, 1) == 1);
    pre = len - 32'(on_fall);
    for (int unsigned i = 0; i < pre; i++) begin
      if ($urandom_range(0, 3) == 0) cap_cycle(1, 0);
      cap_cycle(1, 1);
    end
    cap_cycle(0, on_fall);
    m_lines = (m_lines == 255) ? 255 : m_lines + 1;
    if (m_line_pix != TH) m_line_err = 1;
    m_line_pix = 0;
    cap_cycle(0, 0);
    chk("line_cnt", line_cnt, m_lines);
    chk("line_err", line_err, 32'(m_line_err));
    chk("ovf",      ovf,      32'(m_ovf));
  endtask

  task automatic run_lines();
    foreach (g_lens[i]) drive_line(g_lens[i]);
  endtask

  task automatic end_frame(input logic cont);
    cont_mode = cont;
    step(1, 0, 0, 0, 0);
    chk("end_cap_en_pre", cap_en, 1);
    m_frame_cnt = (m_frame_cnt + 1) % 256;
    if (m_lines != TV) m_frame_err = 1;
    step(1, 0, 1, 0, 0);
    chk("done_frame_done", frame_done, 1);
    chk("done_cap_en",     cap_en,     0);
    chk("done_busy",       busy,       1);
    chk("done_ram_we",     ram_we,     0);
    chk("done_frame_cnt",  frame_cnt,  m_frame_cnt);
    chk("done_line_cnt",   line_cnt,   m_lines);
    chk("done_ram_addr",   ram_addr,   m_writes);
    chk("done_line_err",   line_err,   32'(m_line_err));
    chk("done_frame_err",  frame_err,  32'(m_frame_err));
    chk("done_ovf",        ovf,        32'(m_ovf));
    step(1, 0, 0, 0, 0);
    chk("post_frame_done", frame_done, 0);
    chk("post_busy",       busy,       32'(cont));
  endtask

  task automatic nominal_lens(input int unsigned n);
    g_lens.delete();
    for (int unsigned i = 0; i < n; i++) g_lens.push_back(TH);
  endtask

  task automatic random_lens();
    int unsigned n;
    g_lens.delete();
    n = $urandom_range(TV - 1, TV + 1);
    for (int unsigned i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 7) g_lens.push_back(TH);
      else g_lens.push_back($urandom_range(TH - 1, TH + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; VSYNC = 1'b0; HREF = 1'b0; start = 1'b0;
    abort = 1'b0; cont_mode = 1'b0; we_in = 1'b0;
    model_reset();
    #22;
    chk_all_zero("reset");
    @(negedge PCLK);
    RST_N = 1'b1;

    // Start in the middle of an active line; full nominal frame
    do_start(1, 1);
    sync_in(1);
    nominal_lens(TV);
    run_lines();
    end_frame(0);
    chk("single_final_addr", ram_addr, FULL);

    // Short line sets sticky line_err, cleared only by the next start
    do_start(0, 0);
    sync_in(1);
    nominal_lens(TV);
    g_lens[2] = TH - 1;
    run_lines();
    end_frame(0);
    for (int i = 0; i < 3; i++) begin
      step(i[0], 0, 1, 0, 0);
      chk("sticky_line_err", line_err, 1);
      chk("idle_ram_we",     ram_we,   0);
    end
    do_start(0, 0);
    sync_in(1);
    nominal_lens(TV);
    run_lines();
    end_frame(0);

    // One line too many: overflow, address holds at full
    do_start(0, 0);
    sync_in(1);
    nominal_lens(TV + 1);
    run_lines();
    end_frame(0);
    chk("ovf_final_addr", ram_addr, FULL);

    // Continuous capture of three randomized frames
    do_start(0, 0);
    sync_in(1);
    random_lens(); run_lines(); end_frame(1);
    sync_in(0);
    random_lens(); run_lines(); end_frame(1);
    sync_in(0);
    random_lens(); run_lines(); end_frame(0);
    chk("cont_frame_cnt", frame_cnt, 3);

    // Abort during CAPTURE: idle next cycle, counters and flags hold
    do_start(0, 0);
    sync_in(1);
    cap_cycle(1, 1); cap_cycle(1, 1); cap_cycle(1, 1);
    step(0, 1, 0, 0, 1);
    chk("abort_cap_en_pre", cap_en, 1);
    step(0, 1, 0, 0, 0);
    chk("abort_cap_en",    cap_en,    0);
    chk("abort_busy",      busy,      0);
    chk("abort_ram_addr",  ram_addr,  m_writes);
    chk("abort_frame_cnt", frame_cnt, m_frame_cnt);
    chk("abort_line_err",  line_err,  32'(m_line_err));
    step(1, 0, 1, 0, 0);
    chk("abort_stay_idle", busy, 0);
    chk("abort_ram_we",    ram_we, 0);

    // Abort wins over a simultaneous start
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("abort_vs_start_busy", busy, 0);

    // Abort while armed
    do_start(0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("abort_arm_busy", busy, 0);

    // Asynchronous reset in the middle of a line
    do_start(0, 0);
    sync_in(1);
    cap_cycle(1, 1); cap_cycle(1, 1);
    @(negedge PCLK);
    HREF = 1'b1; we_in = 1'b1;
    #2 RST_N = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(negedge PCLK);
    RST_N = 1'b1;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("post_rst_busy",   busy,   0);
    chk("post_rst_cap_en", cap_en, 0);
    chk("post_rst_ram_we", ram_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
